sa_cache_wb: RTL and testbench
==============================

# sa_cache_wb

Parametrised set-associative byte-access cache with write-back/write-allocate policy, per-set FIFO replacement with invalid-way-first fill, and ready/valid handshakes to the requester and to memory. It succeeds the fixed 4-way, 8-set, 32-byte-block cache by generalising geometry and by adding dirty tracking. Victims are evicted to memory only when dirty. It sits between a byte-wide load/store requester and the block-wide memory interface.

## Interface
- ADDR_W, 32: byte address width.
- WAYS, 4: associativity; power of two, ≥2.
- SETS, 8: number of sets; power of two, ≥2.
- BLOCK_BYTES, 32: bytes per block; power of two, ≥4.
- Derived: OFF_W=clog2(BLOCK_BYTES), IDX_W=clog2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W, BLK_W=ADDR_W-OFF_W.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid / req_ready  in / out  1  request handshake.
- req_write  in  1  1=store byte, 0=load byte.
- req_addr  in  ADDR_W  byte address, split {tag, index, offset}.
- req_wdata  in  8  store byte.
- resp_valid  out  1  one-cycle pulse; completes the request.
- resp_rdata  out  8  loaded byte, or stored byte for writes.
- wb_valid / wb_ready  out / in  1  victim write-back handshake.
- wb_addr  out  BLK_W  victim block address {tag, index}.
- wb_data  out  8·BLOCK_BYTES  victim block; byte i at bits [8i+7:8i].
- mem_rd_req  out  1  refill request, level, held until data returns.
- mem_rd_addr  out  BLK_W  missing block address.
- mem_rd_valid  in  1  one-cycle pulse carrying refill data.
- mem_rd_data  in  8·BLOCK_BYTES  refill block.

## Operation
- FSM states: IDLE, LOOKUP, EVICT, REFILL.
- IDLE: req_ready=1. On req_valid, latch addr/write/wdata and go to LOOKUP. All other states: req_ready=0.
- LOOKUP: compare the latched tag against all valid ways of the set.
  - Hit, load: resp_rdata=byte[offset], resp_valid=1, go to IDLE.
  - Hit, store: write byte, set dirty, resp_rdata=wdata, resp_valid=1, go to IDLE.
  - Miss: select victim = lowest-index invalid way; if none, the way at the set's FIFO pointer. Victim valid and dirty → EVICT; otherwise → REFILL.
- EVICT: wb_valid=1 with wb_addr/wb_data stable until wb_ready is sampled high; then go to REFILL.
- REFILL: mem_rd_req=1 and mem_rd_addr stable until mem_rd_valid.
  - On mem_rd_valid, install the block in the victim way: valid=1, dirty=0, tag updated.
  - If all ways were valid at victim selection, advance the set's FIFO pointer (mod WAYS).
  - Return to LOOKUP; the replayed lookup hits.
- mem_rd_valid outside REFILL and wb_ready outside EVICT are ignored.
- The victim index is registered at the LOOKUP miss; it does not change until the refill installs.

## Timing
- Reset values: req_ready=1 (state IDLE); resp_valid, wb_valid, mem_rd_req = 0; resp_rdata, wb_addr, mem_rd_addr = 0; all valid/dirty bits = 0; all FIFO pointers = 0. The data array is not reset.
- Hit latency: resp_valid is asserted 1 cycle after the acceptance edge. Maximum throughput is one request per 2 cycles.
- Clean miss: acceptance → LOOKUP → REFILL (wait) → LOOKUP → response. This is 3 cycles plus memory latency.
- Dirty miss: adds the EVICT cycles, minimum 1.
- Reset mid-operation: the transaction is abandoned and outputs drop asynchronously. A partially refilled block is never marked valid.

## Structure
- Package cache_pkg holds the state enum, the derived-width functions and the block/tag typedefs; these are shared with the memory-side model.
- Sub-module cache_fifo_repl holds the SETS×clog2(WAYS) pointer array with an advance port. It replaces the fixed FIFO block.
- Tag, valid and dirty bits are flops. The data array is a SETS×WAYS block register array with byte-write enable.

## Test plan
- After reset, load 0x0000_0104 → miss, no wb_valid; mem_rd_addr=0x000_0008. Return a block with byte i=0x10+i → resp_rdata=0x14.
- Store 0xAB to 0x0000_0104, then load it → both hit with resp_valid 1 cycle after acceptance; load returns 0xAB; no memory traffic.
- Store 0x5A to 0x000, then load 0x100, 0x200, 0x300 (all set 0, ways 0–3); load 0x400 → way 0 evicted. Expect wb_addr=0x000_0000 with wb_data byte0=0x5A, then a refill of 0x000_0020.
- Repeat the previous scenario, then load 0x500 → way 1 (clean) replaced with no wb_valid; the pointer advances to 2.
- Hold wb_ready low for 10 cycles in EVICT → wb_valid, wb_addr and wb_data stay stable, with no mem_rd_req and req_ready=0.
- Assert reset during REFILL, then load the same address → all outputs at reset values, and the load misses again.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the set-associative write-back cache
// and its memory-side model.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        EVICT,
        REFILL
    } cacheState_e;

    function automatic int offWidth(input int blockBytes);
        return $clog2(blockBytes);
    endfunction

    function automatic int idxWidth(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tagWidth(input int addrW, input int sets, input int blockBytes);
        return addrW - $clog2(sets) - $clog2(blockBytes);
    endfunction

    function automatic int blkWidth(input int addrW, input int blockBytes);
        return addrW - $clog2(blockBytes);
    endfunction

    // Default geometry, used by the memory-side model
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_SETS        = 8;
    localparam int DEF_BLOCK_BYTES = 32;

    typedef logic [8*DEF_BLOCK_BYTES-1:0] blockData_t;
    typedef logic [tagWidth(DEF_ADDR_W, DEF_SETS, DEF_BLOCK_BYTES)-1:0] tag_t;
    typedef logic [blkWidth(DEF_ADDR_W, DEF_BLOCK_BYTES)-1:0] blockAddr_t;

endpackage

// File: rtl/cache_fifo_repl.sv
// Per-set FIFO replacement pointers; one pointer advances per install into a full set.
module cache_fifo_repl #(
    parameter int SETS = 8,
    parameter int WAYS = 4,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rdIdx,
    output logic [WAY_W-1:0] rdPtr,
    input  logic             advance,
    input  logic [IDX_W-1:0] advIdx
);

    logic [WAY_W-1:0] ptrArr [SETS];

    // WAYS is a power of two, so the natural wrap gives mod-WAYS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) ptrArr[s] <= '0;
        end else if (advance) begin
            ptrArr[advIdx] <= ptrArr[advIdx] + WAY_W'(1);
        end
    end

    assign rdPtr = ptrArr[rdIdx];

endmodule

// File: rtl/sa_cache_wb.sv
// Set-associative byte-access cache, write-back / write-allocate, FIFO replacement
// with invalid-way-first fill.
//
//   state  | meaning
//   IDLE   | ready for a request; latch it on req_valid
//   LOOKUP | tag compare; respond on hit, pick victim on miss
//   EVICT  | present dirty victim on wb_*, wait for wb_ready
//   REFILL | request missing block, install on mem_rd_valid
module sa_cache_wb
    import cache_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int WAYS        = 4,
    parameter int SETS        = 8,
    parameter int BLOCK_BYTES = 32,
    localparam int OFF_W = offWidth(BLOCK_BYTES),
    localparam int IDX_W = idxWidth(SETS),
    localparam int TAG_W = tagWidth(ADDR_W, SETS, BLOCK_BYTES),
    localparam int BLK_W = blkWidth(ADDR_W, BLOCK_BYTES),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [7:0]               req_wdata,
    output logic                     resp_valid,
    output logic [7:0]               resp_rdata,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [BLK_W-1:0]         wb_addr,
    output logic [8*BLOCK_BYTES-1:0] wb_data,
    output logic                     mem_rd_req,
    output logic [BLK_W-1:0]         mem_rd_addr,
    input  logic                     mem_rd_valid,
    input  logic [8*BLOCK_BYTES-1:0] mem_rd_data
);

    localparam int BLK_BITS = 8 * BLOCK_BYTES;

    cacheState_e state, nextState;

    logic [ADDR_W-1:0] addrQ;
    logic              writeQ;
    logic [7:0]        wdataQ;
    logic [WAY_W-1:0]  victimQ;
    logic              allValidQ;

    logic [TAG_W-1:0]    tagArr   [SETS][WAYS];
    logic [WAYS-1:0]     validArr [SETS];
    logic [WAYS-1:0]     dirtyArr [SETS];
    logic [BLK_BITS-1:0] dataArr  [SETS][WAYS];

    logic [IDX_W-1:0] setIdx;
    logic [TAG_W-1:0] tagQ;
    logic [OFF_W-1:0] offQ;
    logic             hit;
    logic [WAY_W-1:0] hitWay;
    logic [WAY_W-1:0] victimSel;
    logic [WAY_W-1:0] fifoPtr;
    logic [7:0]       hitByte;
    logic             storeEn;
    logic             missEn;
    logic             installEn;

    assign setIdx  = addrQ[OFF_W +: IDX_W];
    assign tagQ    = addrQ[ADDR_W-1 -: TAG_W];
    assign offQ    = addrQ[OFF_W-1:0];
    assign hitByte = dataArr[setIdx][hitWay][{offQ, 3'b000} +: 8];

    always_comb begin
        hit       = 1'b0;
        hitWay    = '0;
        victimSel = fifoPtr;
        for (int w = 0; w < WAYS; w++) begin
            if (validArr[setIdx][w] && tagArr[setIdx][w] == tagQ) begin
                hit    = 1'b1;
                hitWay = WAY_W'(w);
            end
        end
        // Descending scan leaves the lowest-index invalid way selected
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!validArr[setIdx][w]) victimSel = WAY_W'(w);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        wb_valid    = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        mem_rd_req  = 1'b0;
        mem_rd_addr = '0;
        storeEn     = 1'b0;
        missEn      = 1'b0;
        installEn   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) nextState = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    resp_rdata = writeQ ? wdataQ : hitByte;
                    storeEn    = writeQ;
                    nextState  = IDLE;
                end else begin
                    missEn    = 1'b1;
                    nextState = (validArr[setIdx][victimSel] && dirtyArr[setIdx][victimSel])
                                ? EVICT : REFILL;
                end
            end
            EVICT: begin
                wb_valid = 1'b1;
                wb_addr  = {tagArr[setIdx][victimQ], setIdx};
                wb_data  = dataArr[setIdx][victimQ];
                if (wb_ready) nextState = REFILL;
            end
            REFILL: begin
                mem_rd_req  = 1'b1;
                mem_rd_addr = addrQ[ADDR_W-1:OFF_W];
                if (mem_rd_valid) begin
                    installEn = 1'b1;
                    nextState = LOOKUP;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addrQ     <= '0;
            writeQ    <= 1'b0;
            wdataQ    <= '0;
            victimQ   <= '0;
            allValidQ <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                validArr[s] <= '0;
                dirtyArr[s] <= '0;
                for (int w = 0; w < WAYS; w++) tagArr[s][w] <= '0;
            end
        end else begin
            if (state == IDLE && req_valid) begin
                addrQ  <= req_addr;
                writeQ <= req_write;
                wdataQ <= req_wdata;
            end
            if (missEn) begin
                victimQ   <= victimSel;
                allValidQ <= &validArr[setIdx];
            end
            if (storeEn) dirtyArr[setIdx][hitWay] <= 1'b1;
            if (installEn) begin
                validArr[setIdx][victimQ] <= 1'b1;
                dirtyArr[setIdx][victimQ] <= 1'b0;
                tagArr[setIdx][victimQ]   <= tagQ;
            end
        end
    end

    // Data array carries no reset; validity is owned by validArr
    always_ff @(posedge clk) begin
        if (storeEn) dataArr[setIdx][hitWay][{offQ, 3'b000} +: 8] <= wdataQ;
        if (installEn) dataArr[setIdx][victimQ] <= mem_rd_data;
    end

    cache_fifo_repl #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) uFifoRepl (
        .clk     (clk),
        .reset   (reset),
        .rdIdx   (setIdx),
        .rdPtr   (fifoPtr),
        .advance (installEn && allValidQ),
        .advIdx  (setIdx)
    );

endmodule

// File: tb/tb_sa_cache_wb.sv
// Directed bench for sa_cache_wb: block-level cache model plus flat byte memories
// supply expected responses, write-backs and refills.
`timescale 1ns/1ps
module tb_sa_cache_wb;

    localparam int ADDR_W      = 32;
    localparam int WAYS        = 4;
    localparam int SETS        = 8;
    localparam int BLOCK_BYTES = 32;
    localparam int BLK_W       = 27;
    localparam int BB          = 8 * BLOCK_BYTES;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [31:0]   req_addr;
    logic [7:0]    req_wdata;
    logic          resp_valid;
    logic [7:0]    resp_rdata;
    logic          wb_valid, wb_ready;
    logic [BLK_W-1:0] wb_addr;
    logic [BB-1:0] wb_data;
    logic          mem_rd_req;
    logic [BLK_W-1:0] mem_rd_addr;
    logic          mem_rd_valid;
    logic [BB-1:0] mem_rd_data;

    always #5 clk = ~clk;

    sa_cache_wb #(
        .ADDR_W(ADDR_W), .WAYS(WAYS), .SETS(SETS), .BLOCK_BYTES(BLOCK_BYTES)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // truthMem: what a load must return; backMem: contents of external memory
    logic [7:0] truthMem [int unsigned];
    logic [7:0] backMem  [int unsigned];

    function automatic logic [7:0] defByte(input logic [31:0] a);
        logic [2:0] hi;
        hi = a[10:8] - 3'd1;
        return 8'h10 + {3'b000, a[4:0]} + {hi, 5'b00000};
    endfunction

    function automatic logic [7:0] truthByte(input logic [31:0] a);
        return truthMem.exists(a) ? truthMem[a] : defByte(a);
    endfunction

    function automatic logic [7:0] backByte(input logic [31:0] a);
        return backMem.exists(a) ? backMem[a] : defByte(a);
    endfunction

    function automatic logic [BB-1:0] truthBlock(input logic [BLK_W-1:0] blk);
        logic [BB-1:0] d;
        for (int i = 0; i < BLOCK_BYTES; i++) d[8*i +: 8] = truthByte({blk, 5'(i)});
        return d;
    endfunction

    function automatic logic [BB-1:0] backBlock(input logic [BLK_W-1:0] blk);
        logic [BB-1:0] d;
        for (int i = 0; i < BLOCK_BYTES; i++) d[8*i +: 8] = backByte({blk, 5'(i)});
        return d;
    endfunction

    // Block-level view of cache contents
    logic [BLK_W-1:0] mBlk   [SETS][WAYS];
    bit               mValid [SETS][WAYS];
    bit               mDirty [SETS][WAYS];
    int               mPtr   [SETS];

    bit               expWb, expRefill;
    logic [BLK_W-1:0] expWbAddr, expRefillAddr;
    logic [BB-1:0]    expWbData;
    logic [7:0]       expRdata;
    int               expLat;

    int               lastLat;
    logic [BLK_W-1:0] lastWbAddr, lastRdAddr;
    logic [BB-1:0]    lastWbData;

    task automatic modelReset();
        for (int s = 0; s < SETS; s++) begin
            mPtr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                mValid[s][w] = 0;
                mDirty[s][w] = 0;
                mBlk[s][w]   = '0;
            end
        end
        // Dirty lines are lost on reset: the visible memory reverts to backing
        truthMem.delete();
        foreach (backMem[k]) truthMem[k] = backMem[k];
    endtask

    task automatic predict(input logic [31:0] addr, input logic wr, input logic [7:0] wd,
                           input int memLat, input int wbHold);
        logic [BLK_W-1:0] blk;
        int idx, way, v;
        bit full;
        blk = addr[31:5];
        idx = int'(blk % SETS);
        way = -1;
        expWb = 0;
        expRefill = 0;
        expWbAddr = '0;
        expWbData = '0;
        expRefillAddr = '0;
        for (int w = 0; w < WAYS; w++)
            if (mValid[idx][w] && mBlk[idx][w] == blk) way = w;
        if (way < 0) begin
            v = -1;
            for (int w = 0; w < WAYS; w++)
                if (v < 0 && !mValid[idx][w]) v = w;
            full = (v < 0);
            if (full) v = mPtr[idx];
            if (mValid[idx][v] && mDirty[idx][v]) begin
                expWb = 1;
                expWbAddr = mBlk[idx][v];
                expWbData = truthBlock(mBlk[idx][v]);
            end
            expRefill = 1;
            expRefillAddr = blk;
            mBlk[idx][v] = blk;
            mValid[idx][v] = 1;
            mDirty[idx][v] = 0;
            if (full) mPtr[idx] = (mPtr[idx] + 1) % WAYS;
            way = v;
        end
        expLat = expRefill ? (2 + memLat + (expWb ? wbHold + 1 : 0)) : 1;
        if (wr) begin
            mDirty[idx][way] = 1;
            truthMem[addr] = wd;
            expRdata = wd;
        end else begin
            expRdata = truthByte(addr);
        end
    endtask

    task automatic checkResetOuts(input string tag);
        check({tag, " req_ready"}, req_ready, 1'b1);
        check({tag, " resp_valid"}, resp_valid, 1'b0);
        check({tag, " wb_valid"}, wb_valid, 1'b0);
        check({tag, " mem_rd_req"}, mem_rd_req, 1'b0);
        check({tag, " resp_rdata"}, resp_rdata, 8'h00);
        check({tag, " wb_addr"}, wb_addr, '0);
        check({tag, " mem_rd_addr"}, mem_rd_addr, '0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        wb_ready = 0; mem_rd_valid = 0; mem_rd_data = '0;
        @(negedge clk);
        @(negedge clk);
        checkResetOuts("reset");
        reset = 1'b0;
        modelReset();
    endtask

    // Issues one request, plays the memory side, checks every busy cycle and the outcome
    task automatic access(input logic [31:0] addr, input logic wr, input logic [7:0] wd,
                          input int memLat, input int wbHold, input bit abort,
                          output logic [7:0] rdata);
        int n, wbCycles, rdCycles, wbCount, rdCount;
        bit done, aborted;
        rdata = '0;
        wbCycles = 0; rdCycles = 0; wbCount = 0; rdCount = 0;
        done = 0; aborted = 0;
        predict(addr, wr, wd, memLat, wbHold);
        @(negedge clk);
        check("req_ready before accept", req_ready, 1'b1);
        req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 0; req_write = 0; req_wdata = '0;
        n = 1;
        while (!done && n <= 200) begin
            wb_ready = 0; mem_rd_valid = 0; mem_rd_data = '0;
            if (resp_valid) begin
                lastLat = n;
                rdata = resp_rdata;
                done = 1;
            end else begin
                check("req_ready while busy", req_ready, 1'b0);
                if (wb_valid) begin
                    if (wbCycles == 0) begin
                        lastWbAddr = wb_addr;
                        lastWbData = wb_data;
                        wbCount++;
                    end else begin
                        check("wb_addr stable", wb_addr, lastWbAddr);
                        check("wb_data stable", wb_data, lastWbData);
                    end
                    check("mem_rd_req during evict", mem_rd_req, 1'b0);
                    wbCycles++;
                    if (wbCycles > wbHold) begin
                        wb_ready = 1;
                        for (int i = 0; i < BLOCK_BYTES; i++)
                            backMem[{wb_addr, 5'(i)}] = wb_data[8*i +: 8];
                    end else begin
                        // stray refill pulse outside REFILL must be ignored
                        mem_rd_valid = 1;
                        mem_rd_data = '1;
                    end
                end
                if (mem_rd_req) begin
                    if (rdCycles == 0) begin
                        lastRdAddr = mem_rd_addr;
                        rdCount++;
                    end else begin
                        check("mem_rd_addr stable", mem_rd_addr, lastRdAddr);
                    end
                    rdCycles++;
                    if (abort) begin
                        reset = 1;
                        #1;
                        checkResetOuts("reset in refill");
                        done = 1;
                        aborted = 1;
                    end else if (rdCycles >= memLat) begin
                        mem_rd_valid = 1;
                        mem_rd_data = backBlock(lastRdAddr);
                    end
                end
                if (!done) begin
                    @(negedge clk);
                    n++;
                end
            end
        end
        wb_ready = 0; mem_rd_valid = 0; mem_rd_data = '0;
        if (aborted) begin
            @(negedge clk);
            reset = 0;
            modelReset();
        end else begin
            check("response within budget", done, 1'b1);
            check("latency", lastLat, expLat);
            check("rdata", rdata, expRdata);
            check("write-back count", wbCount, expWb);
            if (expWb) begin
                check("wb_addr", lastWbAddr, expWbAddr);
                check("wb_data", lastWbData, expWbData);
            end
            check("refill count", rdCount, expRefill);
            if (expRefill) check("mem_rd_addr", lastRdAddr, expRefillAddr);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] rd;
        reset = 1'b1;
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        wb_ready = 0; mem_rd_valid = 0; mem_rd_data = '0;
        doReset();

        // cold miss, then store/load hits
        access(32'h104, 0, 8'h00, 3, 0, 0, rd);
        check("pin load 0x104", rd, 8'h14);
        check("pin refill addr 0x104", lastRdAddr, 27'h8);
        check("pin clean miss latency", lastLat, 5);
        access(32'h104, 1, 8'hAB, 1, 0, 0, rd);
        check("pin store hit latency", lastLat, 1);
        access(32'h104, 0, 8'h00, 1, 0, 0, rd);
        check("pin load after store", rd, 8'hAB);

        // store miss allocates, other set
        access(32'h0E3, 1, 8'h77, 2, 0, 0, rd);
        access(32'h0E3, 0, 8'h00, 1, 0, 0, rd);
        check("pin set7 load", rd, 8'h77);

        // fill set 0, evict dirty way 0 with a long wb_ready stall
        doReset();
        access(32'h000, 1, 8'h5A, 2, 0, 0, rd);
        access(32'h100, 0, 8'h00, 1, 0, 0, rd);
        access(32'h200, 0, 8'h00, 1, 0, 0, rd);
        access(32'h300, 0, 8'h00, 1, 0, 0, rd);
        access(32'h400, 0, 8'h00, 2, 10, 0, rd);
        check("pin evict wb_addr", lastWbAddr, 27'h0);
        check("pin evict byte0", lastWbData[7:0], 8'h5A);
        check("pin evict refill addr", lastRdAddr, 27'h20);
        check("pin evict latency", lastLat, 15);
        check("pin load 0x400", rd, 8'h70);

        // clean replacement follows the FIFO pointer
        access(32'h500, 0, 8'h00, 1, 0, 0, rd);
        check("pin load 0x500", rd, 8'h90);
        check("pin clean replace latency", lastLat, 3);
        access(32'h600, 0, 8'h00, 1, 0, 0, rd);
        access(32'h300, 0, 8'h00, 1, 0, 0, rd);
        check("pin 0x300 still hits", lastLat, 1);
        access(32'h000, 0, 8'h00, 1, 0, 0, rd);
        check("pin written-back byte returns", rd, 8'h5A);
        access(32'h300, 0, 8'h00, 1, 0, 0, rd);

        // reset during refill, then the same load misses again
        access(32'h704, 0, 8'h00, 4, 0, 1, rd);
        access(32'h704, 0, 8'h00, 1, 0, 0, rd);
        check("pin reload after reset latency", lastLat, 3);
        check("pin load 0x704", rd, 8'hD4);
        access(32'h104, 0, 8'h00, 1, 0, 0, rd);
        check("pin 0x104 after reset", rd, 8'h14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
